// File: rtl/ifft8_serial.sv
// 8-point inverse FFT: bins loaded bit-reversed into a frame memory, one conjugate-twiddle butterfly per cycle (3x4), 1/2 scaling per stage.
// Latency: first sample in the 13th cycle after the bin-7 accept, 28-cycle frame period; in_ready low outside LOAD, sample held while !out_ready.
module ifft8_serial #(
    parameter int DATA_W  = 24,
    parameter int TW_W    = 16,
    parameter int TW_FRAC = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [2:0]        out_index,
    output logic              out_last,
    output logic              busy
);
    localparam int PW = DATA_W + TW_W;
    localparam int SW = DATA_W + 2;
    localparam logic signed [SW-1:0]   SAT_HI = SW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SW-1:0]   SAT_LO = -SW'(1 << (DATA_W - 1));
    localparam logic signed [TW_W-1:0] TW_ONE = TW_W'(1 << TW_FRAC);
    localparam logic signed [TW_W-1:0] TW_R2  = TW_W'(16'h16A0);   // cos(pi/4) in Q2.13

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    state_t state, state_nxt;

    logic signed [DATA_W-1:0] mem_re [0:7];
    logic signed [DATA_W-1:0] mem_im [0:7];

    logic [2:0] wr_cnt;
    logic [3:0] bf_cnt;
    logic [1:0] stg, bfy;
    logic       accept, out_hs, last_bfy;
    logic [2:0] addr_p, addr_q, nxt_idx;
    logic [1:0] tw_idx;
    logic signed [TW_W-1:0]   tw_re, tw_im;
    logic signed [DATA_W-1:0] xp_re, xp_im, xq_re, xq_im;
    logic signed [PW-1:0]     prod_rr, prod_ii, prod_ri, prod_ir;
    logic signed [PW:0]       t_re_full, t_im_full;
    logic signed [SW-1:0]     t_re, t_im;
    logic signed [DATA_W-1:0] yp_re, yp_im, yq_re, yq_im;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    assign stg      = bf_cnt[3:2];
    assign bfy      = bf_cnt[1:0];
    assign last_bfy = (stg == 2'd2) && (bfy == 2'd3);
    assign accept   = in_valid & in_ready & (state == LOAD) & !rst;
    assign out_hs   = out_valid & out_ready;
    assign nxt_idx  = out_index + 3'd1;

    always_ff @(posedge clk) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && wr_cnt == 3'd7) state_nxt = COMPUTE;
            COMPUTE: if (last_bfy) state_nxt = UNLOAD;
            UNLOAD:  if (out_hs && out_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Span h = 1<<stg: p has bit stg clear, q is p with that bit set.
    always_comb begin
        addr_p = '0;
        addr_q = '0;
        tw_idx = '0;
        case (stg)
            2'd0: begin
                addr_p = {bfy, 1'b0};
                addr_q = {bfy, 1'b1};
            end
            2'd1: begin
                addr_p = {bfy[1], 1'b0, bfy[0]};
                addr_q = {bfy[1], 1'b1, bfy[0]};
                tw_idx = {bfy[0], 1'b0};
            end
            default: begin
                addr_p = {1'b0, bfy};
                addr_q = {1'b1, bfy};
                tw_idx = bfy;
            end
        endcase
    end

    always_comb begin
        tw_re = TW_ONE;
        tw_im = '0;
        case (tw_idx)
            2'd1:    begin tw_re = TW_R2;  tw_im = TW_R2;  end
            2'd2:    begin tw_re = '0;     tw_im = TW_ONE; end
            2'd3:    begin tw_re = -TW_R2; tw_im = TW_R2;  end
            default: begin tw_re = TW_ONE; tw_im = '0;     end
        endcase
    end

    assign xp_re = mem_re[addr_p];
    assign xp_im = mem_im[addr_p];
    assign xq_re = mem_re[addr_q];
    assign xq_im = mem_im[addr_q];

    assign prod_rr   = PW'(xq_re) * PW'(tw_re);
    assign prod_ii   = PW'(xq_im) * PW'(tw_im);
    assign prod_ri   = PW'(xq_re) * PW'(tw_im);
    assign prod_ir   = PW'(xq_im) * PW'(tw_re);
    assign t_re_full = (PW+1)'(prod_rr) - (PW+1)'(prod_ii);
    assign t_im_full = (PW+1)'(prod_ri) + (PW+1)'(prod_ir);
    assign t_re      = SW'(t_re_full >>> TW_FRAC);
    assign t_im      = SW'(t_im_full >>> TW_FRAC);

    assign yp_re = sat((SW'(xp_re) + t_re) >>> 1);
    assign yp_im = sat((SW'(xp_im) + t_im) >>> 1);
    assign yq_re = sat((SW'(xp_re) - t_re) >>> 1);
    assign yq_im = sat((SW'(xp_im) - t_im) >>> 1);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[bitrev3(wr_cnt)] <= in_real;
            mem_im[bitrev3(wr_cnt)] <= in_imag;
        end else if (state == COMPUTE && !rst) begin
            mem_re[addr_p] <= yp_re;
            mem_im[addr_p] <= yp_im;
            mem_re[addr_q] <= yq_re;
            mem_im[addr_q] <= yq_im;
        end
    end

    // Sample 0 is final after butterfly (2,0); the last butterfly touches only 3 and 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            bf_cnt    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                wr_cnt <= wr_cnt + 3'd1;
                if (wr_cnt == 3'd7) begin
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
            end
            if (state == COMPUTE) begin
                bf_cnt <= last_bfy ? 4'd0 : bf_cnt + 4'd1;
                if (last_bfy) begin
                    out_valid <= 1'b1;
                    out_real  <= mem_re[3'd0];
                    out_imag  <= mem_im[3'd0];
                    out_index <= 3'd0;
                    out_last  <= 1'b0;
                end
            end
            if (state == UNLOAD && out_hs) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    out_index <= nxt_idx;
                    out_real  <= mem_re[nxt_idx];
                    out_imag  <= mem_im[nxt_idx];
                    out_last  <= (nxt_idx == 3'd7);
                end
            end
        end
    end
endmodule

// File: tb/tb_ifft8_serial.sv
// Directed bench for ifft8_serial: hand-computed bin-exact frames, backpressure hold, mid-compute reset.
module tb_ifft8_serial;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic signed [23:0] in_real, in_imag, out_real, out_imag;
    logic [2:0] out_index;

    int vecs = 0;
    int errs = 0;
    logic signed [23:0] fr_re [8];
    logic signed [23:0] fr_im [8];
    int got_re [8];
    int got_im [8];
    int got_idx [8];
    int got_last [8];
    int n_sent, n_got, lat;

    ifft8_serial dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    // Ends 1 time unit after the edge that accepts bin 7.
    task automatic send_frame(output int sent);
        int guard;
        sent = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_real  = fr_re[k];
            in_imag  = fr_im[k];
            guard = 0;
            while (!in_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (in_ready) begin
                tick();
                sent++;
            end
        end
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the bin-7 accept edge.
    task automatic recv_frame(output int got, output int first_cyc);
        int cyc;
        cyc = 1;
        got = 0;
        first_cyc = -1;
        out_ready = 1'b1;
        while (got < 8 && cyc < 200) begin
            if (out_valid) begin
                if (got == 0) first_cyc = cyc;
                got_re[got]   = int'(out_real);
                got_im[got]   = int'(out_imag);
                got_idx[got]  = int'(out_index);
                got_last[got] = int'(out_last);
                got++;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
        tick(); tick();
        rst = 1'b0;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vecs++; if (out_real !== 24'sd0 || out_imag !== 24'sd0) begin errs++; $display("FAIL reset_out_data got=(%0d,%0d) exp=(0,0)", out_real, out_imag); end
        vecs++; if (out_index !== 3'd0 || out_last !== 1'b0) begin errs++; $display("FAIL reset_out_index got=%0d last=%b exp=0/0", out_index, out_last); end
    endtask

    task automatic test_dc_bins();
        int er [8];
        int ei [8];
        clear_frame();
        for (int k = 0; k < 8; k++) fr_re[k] = 24'sd8192;
        er = '{8192, 0, 0, 0, 0, 0, 0, 0};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(n_sent);
        vecs++; if (n_sent !== 8) begin errs++; $display("FAIL dc_sent got=%0d exp=8", n_sent); end
        vecs++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL dc_compute_flags busy=%b in_ready=%b exp=1/0", busy, in_ready); end
        recv_frame(n_got, lat);
        vecs++; if (n_got !== 8) begin errs++; $display("FAIL dc_count got=%0d exp=8", n_got); end
        vecs++; if (lat !== 13) begin errs++; $display("FAIL dc_latency got=%0d exp=13", lat); end
        for (int n = 0; n < 8; n++) begin
            vecs++;
            if (got_re[n] !== er[n] || got_im[n] !== ei[n] || got_idx[n] !== n || got_last[n] !== ((n == 7) ? 1 : 0)) begin
                errs++;
                $display("FAIL dc_sample n=%0d got=(%0d,%0d) idx=%0d last=%0d exp=(%0d,%0d)", n, got_re[n], got_im[n], got_idx[n], got_last[n], er[n], ei[n]);
            end
        end
        vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL dc_return_load out_valid=%b in_ready=%b busy=%b exp=0/1/0", out_valid, in_ready, busy); end
    endtask

    task automatic test_bin0();
        int er [8];
        int ei [8];
        clear_frame();
        fr_re[0] = 24'sd8000;
        fr_im[0] = -24'sd4000;
        er = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        ei = '{-500, -500, -500, -500, -500, -500, -500, -500};
        send_frame(n_sent);
        recv_frame(n_got, lat);
        vecs++; if (n_got !== 8) begin errs++; $display("FAIL bin0_count got=%0d exp=8", n_got); end
        for (int n = 0; n < 8; n++) begin
            vecs++;
            if (got_re[n] !== er[n] || got_im[n] !== ei[n] || got_idx[n] !== n) begin
                errs++;
                $display("FAIL bin0_sample n=%0d got=(%0d,%0d) idx=%0d exp=(%0d,%0d)", n, got_re[n], got_im[n], got_idx[n], er[n], ei[n]);
            end
        end
    endtask

    task automatic test_bin1();
        int er [8];
        int ei [8];
        clear_frame();
        fr_re[1] = 24'sd8000;
        er = '{1000, 707, 0, -708, -1000, -707, 0, 707};
        ei = '{0, 707, 1000, 707, 0, -707, -1000, -707};
        send_frame(n_sent);
        recv_frame(n_got, lat);
        vecs++; if (n_got !== 8) begin errs++; $display("FAIL bin1_count got=%0d exp=8", n_got); end
        for (int n = 0; n < 8; n++) begin
            vecs++;
            if (got_re[n] !== er[n] || got_im[n] !== ei[n] || got_idx[n] !== n) begin
                errs++;
                $display("FAIL bin1_sample n=%0d got=(%0d,%0d) idx=%0d exp=(%0d,%0d)", n, got_re[n], got_im[n], got_idx[n], er[n], ei[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        int er [8];
        int ei [8];
        int n, hold, cyc;
        clear_frame();
        fr_re[3] = 24'sd8000;
        er = '{1000, -708, 0, 707, -1000, 707, 0, -707};
        ei = '{0, 707, -1000, 707, 0, -707, 1000, -707};
        send_frame(n_sent);
        n = 0; hold = 0; cyc = 0;
        while (n < 8 && cyc < 200) begin
            in_valid = cyc[0];
            in_real  = 24'sh123456;
            in_imag  = -24'sd77;
            vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            if (out_valid && out_index == 3'd3 && hold < 5) begin
                out_ready = 1'b0;
                vecs++;
                if (out_real !== 24'sd707 || out_imag !== 24'sd707 || out_index !== 3'd3 || out_valid !== 1'b1) begin
                    errs++;
                    $display("FAIL bp_hold cyc=%0d got=(%0d,%0d) idx=%0d exp=(707,707) idx=3", hold, out_real, out_imag, out_index);
                end
                hold++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                got_re[n]  = int'(out_real);
                got_im[n]  = int'(out_imag);
                got_idx[n] = int'(out_index);
                n++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        vecs++; if (n !== 8 || hold !== 5) begin errs++; $display("FAIL bp_count got=%0d hold=%0d exp=8/5", n, hold); end
        for (int i = 0; i < 8; i++) begin
            vecs++;
            if (got_re[i] !== er[i] || got_im[i] !== ei[i] || got_idx[i] !== i) begin
                errs++;
                $display("FAIL bp_sample n=%0d got=(%0d,%0d) idx=%0d exp=(%0d,%0d)", i, got_re[i], got_im[i], got_idx[i], er[i], ei[i]);
            end
        end
    endtask

    task automatic test_full_scale();
        int er [8];
        int ei [8];
        clear_frame();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 24'(-8388608);
            fr_im[k] = 24'(-8388608);
        end
        er = '{-8388608, 0, 0, 0, 0, 0, 0, 0};
        ei = '{-8388608, 0, 0, 0, 0, 0, 0, 0};
        send_frame(n_sent);
        recv_frame(n_got, lat);
        vecs++; if (n_got !== 8) begin errs++; $display("FAIL neg_fs_count got=%0d exp=8", n_got); end
        for (int n = 0; n < 8; n++) begin
            vecs++;
            if (got_re[n] !== er[n] || got_im[n] !== ei[n]) begin
                errs++;
                $display("FAIL neg_fs_sample n=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, got_re[n], got_im[n], er[n], ei[n]);
            end
        end
        clear_frame();
        fr_re[0] = 24'(8388607);
        send_frame(n_sent);
        recv_frame(n_got, lat);
        vecs++; if (n_got !== 8) begin errs++; $display("FAIL pos_fs_count got=%0d exp=8", n_got); end
        for (int n = 0; n < 8; n++) begin
            vecs++;
            if (got_re[n] !== 1048575 || got_im[n] !== 0) begin
                errs++;
                $display("FAIL pos_fs_sample n=%0d got=(%0d,%0d) exp=(1048575,0)", n, got_re[n], got_im[n]);
            end
        end
    endtask

    task automatic test_reset_compute();
        clear_frame();
        fr_re[1] = 24'sd5000;
        fr_im[6] = 24'sd3000;
        send_frame(n_sent);
        for (int i = 0; i < 5; i++) tick();
        vecs++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL rc_in_compute busy=%b out_valid=%b exp=1/0", busy, out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rc_after_reset in_ready=%b out_valid=%b busy=%b exp=1/0/0", in_ready, out_valid, busy); end
        clear_frame();
        fr_re[0] = 24'sd800;
        send_frame(n_sent);
        recv_frame(n_got, lat);
        vecs++; if (n_got !== 8 || lat !== 13) begin errs++; $display("FAIL rc_count got=%0d lat=%0d exp=8/13", n_got, lat); end
        for (int n = 0; n < 8; n++) begin
            vecs++;
            if (got_re[n] !== 100 || got_im[n] !== 0 || got_idx[n] !== n) begin
                errs++;
                $display("FAIL rc_sample n=%0d got=(%0d,%0d) idx=%0d exp=(100,0)", n, got_re[n], got_im[n], got_idx[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc_bins();
        test_bin0();
        test_bin1();
        test_backpressure();
        test_full_scale();
        test_reset_compute();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
